// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
//
// Registered array of independent one-bit half adders. Each lane i computes
//   sum[i]   = a[i] ^ b[i]
//   carry[i] = a[i] & b[i]
// and there is no carry between lanes. An input qualified by in_valid is
// captured on the rising clk edge. Its result appears on sum/carry after that
// edge, and out_valid is high for exactly that one cycle. When in_valid is low,
// sum/carry keep their last values and a/b are ignored. The block accepts one
// input per cycle and has no backpressure.
//
// Optional feature (macro HALF_ADDER_STATS_EN):
//   Adds the carry_count output. It counts accepted inputs that produce a
//   carry in at least one lane, and it saturates at 16'hFFFF.
//
// Parameters:
//   WIDTH        number of independent lanes (1..64)
//
// Ports:
//   clk          single clock; all state updates on the rising edge
//   rst          synchronous, active-high reset; overrides in_valid
//   in_valid     a/b carry a new operand pair this cycle
//   a, b         per-lane addends (WIDTH bits)
//   out_valid    sum/carry hold a result captured on the previous edge
//   sum          per-lane sum bit (WIDTH bits)
//   carry        per-lane carry bit (WIDTH bits)
//   carry_count  carry-event counter, 16 bits (HALF_ADDER_STATS_EN only)
// -----------------------------------------------------------------------------
module half_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
`ifdef HALF_ADDER_STATS_EN
  ,
  output logic [15:0]      carry_count
`endif
);

  // ---------------------------------------------------------------------------
  // Combinational lane logic
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;

  // Bitwise operators keep the lanes independent: no bit reads its neighbour.
  assign w_sum   = a ^ b;
  assign w_carry = a & b;

  // ---------------------------------------------------------------------------
  // Result registers
  // ---------------------------------------------------------------------------
  logic             r_valid;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_carry;

  // NOTE: state is updated with non-blocking assignments only. Every register
  // then samples values from before the edge, so the order of the statements
  // below does not change the behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset has priority: an operand pair presented with rst is dropped, and
      // any result still in the registers is cleared.
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_carry <= '0;
    end else begin
      r_valid <= in_valid;
      // NOTE: the missing else branch is intentional. In a clocked block it
      // becomes a load enable and the flops hold their value. The same pattern
      // in combinational logic would infer a latch.
      if (in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_carry;
      end
    end
  end

  assign out_valid = r_valid;
  assign sum       = r_sum;
  assign carry     = r_carry;

`ifdef HALF_ADDER_STATS_EN
  // ---------------------------------------------------------------------------
  // Carry-event statistics
  // ---------------------------------------------------------------------------
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic        w_any_carry;
  logic        w_cnt_inc;
  logic [15:0] r_carry_count;

  // One event per accepted input, however many of its lanes carry.
  assign w_any_carry = |w_carry;

  // Stop at CNT_MAX rather than wrapping back to zero.
  assign w_cnt_inc = in_valid && w_any_carry && (r_carry_count != CNT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_carry_count <= '0;
    end else if (w_cnt_inc) begin
      r_carry_count <= r_carry_count + 16'd1;
    end
  end

  assign carry_count = r_carry_count;
`endif

endmodule

// File: tb/tb_half_adder.sv
// -----------------------------------------------------------------------------
// tb_half_adder
//
// Self-checking bench for half_adder. It instantiates the block twice:
//   u_w1  WIDTH=1  (truth table, hold, reset)
//   u_w8  WIDTH=8  (lane independence, random back-to-back stream, stats)
//
// Each accepted input pushes its expected sum/carry onto a per-instance queue.
// A monitor runs on the falling edge. It checks out_valid against the
// expected one-cycle-delayed valid and pops the queue whenever a result is
// due. It then checks that sum/carry equal the most recent expected result,
// which also covers the hold behaviour. Each scenario task adds its own
// inline checks on top of the monitor.
// The stats scenario is compiled only when HALF_ADDER_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_half_adder;

  typedef struct packed {
    logic [7:0] s;
    logic [7:0] c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  = 1'b1;
  logic       iv1  = 1'b0;
  logic       a1   = 1'b0;
  logic       b1   = 1'b0;
  logic       ov1;
  logic       s1;
  logic       c1;
  logic       iv8  = 1'b0;
  logic [7:0] a8   = 8'h00;
  logic [7:0] b8   = 8'h00;
  logic       ov8;
  logic [7:0] s8;
  logic [7:0] c8;
`ifdef HALF_ADDER_STATS_EN
  logic [15:0] cc1;
  logic [15:0] cc8;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  exp_t q1[$];
  exp_t q8[$];
  exp_t h1 = '0;
  exp_t h8 = '0;

  logic eov1     = 1'b0;
  logic eov8     = 1'b0;
  logic last_rst = 1'b1;
  logic mon_en   = 1'b0;

  half_adder #(.WIDTH(1)) u_w1 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (iv1),
    .a          (a1),
    .b          (b1),
    .out_valid  (ov1),
    .sum        (s1),
    .carry      (c1)
`ifdef HALF_ADDER_STATS_EN
    ,
    .carry_count(cc1)
`endif
  );

  half_adder #(.WIDTH(8)) u_w8 (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (iv8),
    .a          (a8),
    .b          (b8),
    .out_valid  (ov8),
    .sum        (s8),
    .carry      (c8)
`ifdef HALF_ADDER_STATS_EN
    ,
    .carry_count(cc8)
`endif
  );

  // Expected valid: the input qualifier delayed one edge, killed by reset.
  always @(posedge clk) begin
    eov1     <= iv1 && !rst;
    eov8     <= iv8 && !rst;
    last_rst <= rst;
  end

  // Scoreboard monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (last_rst) begin
        h1 = '0;
        h8 = '0;
      end
      n_tests++;
      if (ov1 !== eov1) begin
        n_fail++;
        $display("FAIL sb_w1_valid: got %b expected %b at %0t", ov1, eov1, $time);
      end
      if (eov1) begin
        if (q1.size() == 0) begin
          n_fail++;
          $display("FAIL sb_w1_underflow: result due but queue empty at %0t", $time);
        end else begin
          h1 = q1.pop_front();
        end
      end
      n_tests++;
      if (s1 !== h1.s[0] || c1 !== h1.c[0]) begin
        n_fail++;
        $display("FAIL sb_w1_data: got sum=%b carry=%b expected sum=%b carry=%b at %0t",
                 s1, c1, h1.s[0], h1.c[0], $time);
      end

      n_tests++;
      if (ov8 !== eov8) begin
        n_fail++;
        $display("FAIL sb_w8_valid: got %b expected %b at %0t", ov8, eov8, $time);
      end
      if (eov8) begin
        if (q8.size() == 0) begin
          n_fail++;
          $display("FAIL sb_w8_underflow: result due but queue empty at %0t", $time);
        end else begin
          h8 = q8.pop_front();
        end
      end
      n_tests++;
      if (s8 !== h8.s || c8 !== h8.c) begin
        n_fail++;
        $display("FAIL sb_w8_data: got sum=%h carry=%h expected sum=%h carry=%h at %0t",
                 s8, c8, h8.s, h8.c, $time);
      end
      if (ov8 === 1'b1) begin
        n_tests++;
        if ((s8 & c8) !== 8'h00) begin
          n_fail++;
          $display("FAIL sb_w8_exclusive: sum&carry got %h expected 00", s8 & c8);
        end
      end
    end
  end

  // Drive one cycle of stimulus just after the rising edge. Inputs that will be
  // accepted at the next edge push their expected result.
  task automatic drive(input logic r, input logic v1, input logic x1, input logic y1,
                       input logic v8, input logic [7:0] x8, input logic [7:0] y8);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r;
    iv1 = v1;
    a1  = x1;
    b1  = y1;
    iv8 = v8;
    a8  = x8;
    b8  = y8;
    if (v1 && !r) begin
      e.s = {7'b0, x1 ^ y1};
      e.c = {7'b0, x1 & y1};
      q1.push_back(e);
    end
    if (v8 && !r) begin
      e.s = x8 ^ y8;
      e.c = x8 & y8;
      q8.push_back(e);
    end
  endtask

  task automatic chk1(input string name, input logic eo, input logic es, input logic ec);
    n_tests++;
    if (ov1 !== eo || s1 !== es || c1 !== ec) begin
      n_fail++;
      $display("FAIL %s: got valid=%b sum=%b carry=%b expected valid=%b sum=%b carry=%b",
               name, ov1, s1, c1, eo, es, ec);
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
    @(negedge clk);
    chk1("reset_w1_state", 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF);
    @(negedge clk);
    n_tests++;
    if (ov8 !== 1'b0 || s8 !== 8'h00 || c8 !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_w8_state: got valid=%b sum=%h carry=%h expected 0/00/00", ov8, s8, c8);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk1("reset_input_dropped", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_truth_table();
    logic [1:0] ab [4];
    logic [1:0] sc [4];
    ab = '{2'b00, 2'b01, 2'b10, 2'b11};
    sc = '{2'b00, 2'b10, 2'b10, 2'b01};
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) drive(1'b0, 1'b1, ab[i][1], ab[i][0], 1'b0, 8'h00, 8'h00);
      else       drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      if (i > 0) chk1($sformatf("truth_%0d", i - 1), 1'b1, sc[i-1][1], sc[i-1][0]);
    end
  endtask

  task automatic test_lanes();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 8'hCC);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    n_tests++;
    if (ov8 !== 1'b1 || s8 !== 8'h3C || c8 !== 8'hC0) begin
      n_fail++;
      $display("FAIL lanes_f0_cc: got valid=%b sum=%h carry=%h expected 1/3c/c0", ov8, s8, c8);
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      // a/b on the wide lane toggle while unqualified and must be ignored.
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
      @(negedge clk);
      chk1($sformatf("hold_%0d", i), (i == 0), 1'b0, 1'b1);
    end
  endtask

  task automatic test_reset_midstream();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk1("rst_mid_before", 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk1("rst_mid_cleared", 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk1("rst_mid_resume", 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    // Random stream with occasional idle cycles. The monitor checks every
    // result against the queue.
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
  endtask

`ifdef HALF_ADDER_STATS_EN
  task automatic chk_cnt(input string name, input logic [15:0] exp_cnt);
    n_tests++;
    if (cc8 !== exp_cnt) begin
      n_fail++;
      $display("FAIL %s: got carry_count=%h expected %h", name, cc8, exp_cnt);
    end
  endtask

  task automatic test_stats();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 8'h0F);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'h80);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'hFF);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h0C);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk_cnt("stats_three", 16'd3);
    n_tests++;
    if (cc1 !== 16'd0) begin
      n_fail++;
      $display("FAIL stats_w1_idle: got carry_count=%h expected 0000", cc1);
    end
    // Reach the saturation boundary from reset: 65534 + 1 + 5 carry inputs.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 65534; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h01);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk_cnt("stats_fffe", 16'hFFFE);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 8'h80);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk_cnt("stats_ffff", 16'hFFFF);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 8'hFF);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk_cnt("stats_saturate", 16'hFFFF);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk_cnt("stats_reset", 16'h0000);
  endtask
`endif

  initial begin
    @(posedge clk);
    mon_en = 1'b1;
    test_reset();
    test_truth_table();
    test_lanes();
    test_hold();
    test_reset_midstream();
    test_back_to_back();
`ifdef HALF_ADDER_STATS_EN
    test_stats();
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    n_tests++;
    if (q1.size() != 0 || q8.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d/%0d pending expected 0/0", q1.size(), q8.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
